// File: rtl/sipo_pkg.sv
// Shared definitions for the sipo_deser serial-to-parallel deserialiser:
// counter sizing and parameter legality helpers.
package sipo_pkg;

  // Bit order of the assembled word relative to arrival order.
  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } lane_order_e;

  // Beat counter width; a single-beat word still needs a 1-bit counter port.
  function automatic int cnt_w(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

  // LANES must be 1..WIDTH and divide WIDTH exactly.
  function automatic bit params_ok(input int width, input int lanes);
    if (lanes < 1 || lanes > width) return 1'b0;
    return (width % lanes) == 0;
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready output buffer for sipo_deser. Accepts a completed word
// when empty or draining on the same edge; otherwise drops it and flags overrun.
module sipo_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  output logic             overrun,
  output logic             load_ok
);

  // A full buffer that is being drained this edge can take the next word with no bubble.
  assign load_ok = !q_valid || ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_out   <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (clr) begin
      q_out   <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (load && load_ok) begin
        q_out   <= word;
        q_valid <= 1'b1;
      end else if (ready) begin
        q_valid <= 1'b0;
      end
      if (load && !load_ok) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-to-parallel deserialiser: shifts LANES bits per enabled
// clock into a WIDTH-bit word and hands completed words to a one-entry buffer.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  LANES     = 1,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int BEATS     = WIDTH / LANES,
  localparam int CNT_W     = cnt_w(BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [LANES-1:0] data_in,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             overrun
);

  localparam lane_order_e ORDER = MSB_FIRST ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

  if (!params_ok(WIDTH, LANES)) begin : g_bad_params
    $error("sipo_deser: LANES must be in 1..WIDTH and divide WIDTH exactly");
  end

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt_next;
  logic             last_beat;
  logic             complete;
  logic             load_ok;

  // Lane-order mux: shifted is the next-state value of sr when shift_en is high.
  if (BEATS == 1) begin : g_single_beat
    assign shifted = data_in;
  end else if (ORDER == ORDER_MSB_FIRST) begin : g_msb_first
    assign shifted = {sr[WIDTH-LANES-1:0], data_in};
  end else begin : g_lsb_first
    assign shifted = {data_in, sr[WIDTH-1:LANES]};
  end

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_next = beat_cnt + CNT_W'(1);
    if (last_beat) begin
      cnt_next = '0;
    end
  end

  // sr is deliberately not cleared on completion; the next BEATS beats overwrite it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      beat_cnt <= '0;
    end else if (clr) begin
      sr       <= '0;
      beat_cnt <= '0;
    end else if (shift_en) begin
      sr       <= shifted;
      beat_cnt <= cnt_next;
    end
  end

  assign complete = shift_en && last_beat && !clr;

  sipo_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .load    (complete),
    .word    (shifted),
    .ready   (q_ready),
    .q_out   (q_out),
    .q_valid (q_valid),
    .overrun (overrun),
    .load_ok (load_ok)
  );

  // Drop decisions are already folded into overrun inside the buffer.
  logic unused_load_ok;
  assign unused_load_ok = load_ok;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser: three instances cover 1-lane
// LSB-first, 1-lane MSB-first and 2-lane LSB-first configurations.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       shift_en;
  logic       d1;
  logic       q_ready;
  logic       shift_en2;
  logic [1:0] d2;
  logic       q_ready2;

  logic [7:0] q_lsb, q_msb, q_l2;
  logic       v_lsb, v_msb, v_l2;
  logic [2:0] cnt_lsb, cnt_msb;
  logic [1:0] cnt_l2;
  logic       ovr_lsb, ovr_msb, ovr_l2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .shift_en(shift_en), .data_in(d1),
    .q_ready(q_ready), .q_out(q_lsb), .q_valid(v_lsb), .beat_cnt(cnt_lsb),
    .overrun(ovr_lsb)
  );

  sipo_deser #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .shift_en(shift_en), .data_in(d1),
    .q_ready(q_ready), .q_out(q_msb), .q_valid(v_msb), .beat_cnt(cnt_msb),
    .overrun(ovr_msb)
  );

  sipo_deser #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) u_l2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .shift_en(shift_en2), .data_in(d2),
    .q_ready(q_ready2), .q_out(q_l2), .q_valid(v_l2), .beat_cnt(cnt_l2),
    .overrun(ovr_l2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    shift_en = 1'b1;
    d1       = b;
    @(posedge clk);
    #1;
  endtask

  // Sends w bit 0 first; q_ready is rdy_pre for beats 0..6 and rdy_last on beat 7.
  task automatic send_word(input logic [7:0] w, input logic rdy_pre, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      shift_en = 1'b1;
      d1       = w[i];
      q_ready  = (i == 7) ? rdy_last : rdy_pre;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    shift_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send2(input logic [1:0] d);
    @(negedge clk);
    shift_en2 = 1'b1;
    d2        = d;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] l2_beats [4];
  logic [1:0] l2_cnts  [4];
  logic [7:0] gap_word;

  initial begin
    rst_n = 1'b0; clr = 1'b0; shift_en = 1'b0; d1 = 1'b0; q_ready = 1'b0;
    shift_en2 = 1'b0; d2 = 2'b00; q_ready2 = 1'b0;
    l2_beats = '{2'b01, 2'b10, 2'b11, 2'b00};
    l2_cnts  = '{2'd1, 2'd2, 2'd3, 2'd0};
    #1;
    check("rst_q_out",   q_lsb,   8'h00);
    check("rst_q_valid", v_lsb,   1'b0);
    check("rst_cnt",     cnt_lsb, 3'd0);
    check("rst_overrun", ovr_lsb, 1'b0);
    check("rst_l2_valid", v_l2,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1/2: same serial bits into LSB-first and MSB-first instances
    send_word(8'h4D, 1'b1, 1'b1);
    check("t1_lsb_word",  q_lsb,   8'h4D);
    check("t1_lsb_valid", v_lsb,   1'b1);
    check("t1_cnt_wrap",  cnt_lsb, 3'd0);
    check("t2_msb_word",  q_msb,   8'hB2);
    check("t2_msb_valid", v_msb,   1'b1);
    idle_cycle();
    check("t1_valid_one_cycle", v_lsb, 1'b0);
    check("t2_valid_one_cycle", v_msb, 1'b0);

    // 3: two lanes per beat
    q_ready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send2(l2_beats[i]);
      check($sformatf("t3_cnt_beat%0d", i), cnt_l2, l2_cnts[i]);
    end
    check("t3_l2_word",  q_l2, 8'h39);
    check("t3_l2_valid", v_l2, 1'b1);
    @(negedge clk);
    shift_en2 = 1'b0;

    // 4: overrun with consumer stalled, then drain, then clear
    send_word(8'h4D, 1'b0, 1'b0);
    check("t4_first_word",  q_lsb,   8'h4D);
    check("t4_first_valid", v_lsb,   1'b1);
    check("t4_no_overrun",  ovr_lsb, 1'b0);
    send_word(8'hB2, 1'b0, 1'b0);
    check("t4_word_held",   q_lsb,   8'h4D);
    check("t4_overrun_set", ovr_lsb, 1'b1);
    check("t4_still_valid", v_lsb,   1'b1);
    @(negedge clk);
    shift_en = 1'b0;
    q_ready  = 1'b1;
    @(posedge clk);
    #1;
    check("t4_drained",       v_lsb,   1'b0);
    check("t4_overrun_stick", ovr_lsb, 1'b1);
    @(negedge clk);
    clr      = 1'b1;
    shift_en = 1'b1;
    d1       = 1'b1;
    q_ready  = 1'b0;
    @(posedge clk);
    #1;
    check("t4_clr_overrun", ovr_lsb, 1'b0);
    check("t4_clr_beats",   cnt_lsb, 3'd0);
    check("t4_clr_valid",   v_lsb,   1'b0);
    @(negedge clk);
    clr      = 1'b0;
    shift_en = 1'b0;

    // 5: drain and complete on the same edge
    send_word(8'h11, 1'b0, 1'b0);
    check("t5_first_word", q_lsb, 8'h11);
    send_word(8'h22, 1'b0, 1'b1);
    check("t5_new_word",   q_lsb,   8'h22);
    check("t5_valid_kept", v_lsb,   1'b1);
    check("t5_no_overrun", ovr_lsb, 1'b0);
    @(negedge clk);
    shift_en = 1'b0;
    q_ready  = 1'b1;
    @(posedge clk);
    #1;
    check("t5_drained", v_lsb, 1'b0);

    // 6a: three idle cycles in the middle of a word
    gap_word = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        for (int g = 0; g < 3; g++) idle_cycle();
        check("t6_gap_cnt_hold", cnt_lsb, 3'd4);
      end
      send_bit(gap_word[i]);
    end
    check("t6_gap_word",  q_lsb, 8'h5A);
    check("t6_gap_valid", v_lsb, 1'b1);
    idle_cycle();

    // 6b: asynchronous reset mid-word with a word held
    q_ready = 1'b0;
    send_word(8'h3C, 1'b0, 1'b0);
    check("t6_held_valid", v_lsb, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("t6_mid_cnt", cnt_lsb, 3'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_q_out", q_lsb,   8'h00);
    check("t6_async_valid", v_lsb,   1'b0);
    check("t6_async_cnt",   cnt_lsb, 3'd0);
    check("t6_async_ovr",   ovr_lsb, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    shift_en = 1'b0;
    send_word(8'hC3, 1'b1, 1'b1);
    check("t6_clean_word",  q_lsb, 8'hC3);
    check("t6_clean_valid", v_lsb, 1'b1);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
